// File: rtl/line_scanout.sv
// line_scanout: streams 36-bit line-buffer words out as one 9-bit palette index per pix_ce.
// Defining SCANOUT_CLEAR_EN enables clearing each word on the buffer write port after it is consumed.
module line_scanout #(
    parameter int unsigned WORDS  = 160,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              line_start,
    input  logic              pix_ce,
    input  logic [8:0]        bg_color,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [35:0]       rd_data,
    input  logic [3:0]        rd_updated,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              pix_valid,
    output logic [8:0]        pix_index,
    output logic              busy,
    output logic              line_done
);
    localparam int unsigned DATA_W = 36;
    localparam int unsigned FLAG_W = 4;
    localparam int unsigned PIX_W  = 9;

    typedef enum logic [2:0] {
        IDLE,
        FETCH0,
        FETCH1,
        FETCH2,
        ACTIVE
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [FLAG_W-1:0] upd;
    } word_t;

    state_t            state, state_d;
    word_t             cur, cur_d;
    word_t             nxt, nxt_d;
    logic [ADDR_W-1:0] word, word_d;
    logic [1:0]        slot, slot_d;
    logic              rd_pend, rd_pend_d;

    logic              rd_en_d;
    logic [ADDR_W-1:0] rd_addr_d;
    logic              clr_en_d;
    logic [ADDR_W-1:0] clr_addr_d;
    logic              pix_valid_d;
    logic [PIX_W-1:0]  pix_index_d;
    logic              busy_d;
    logic              line_done_d;

    logic              word_last_c;
    logic              prefetch_ok_c;
    word_t             rd_word_c;

    // Select one slot of a word and substitute the background for empty/transparent pixels.
    function automatic logic [PIX_W-1:0] pick_pixel(input word_t w, input logic [1:0] s,
                                                    input logic [PIX_W-1:0] bg);
        logic       bank;
        logic [7:0] idx;
        logic       upd;
        bank = 1'b0;
        idx  = 8'h00;
        upd  = 1'b0;
        case (s)
            2'd0: begin bank = w.data[35]; idx = w.data[31:24]; upd = w.upd[3]; end
            2'd1: begin bank = w.data[34]; idx = w.data[23:16]; upd = w.upd[2]; end
            2'd2: begin bank = w.data[33]; idx = w.data[15:8];  upd = w.upd[1]; end
            default: begin bank = w.data[32]; idx = w.data[7:0]; upd = w.upd[0]; end
        endcase
        if (!upd || idx[3:0] == 4'h0) begin
            return bg;
        end
        return {bank, idx};
    endfunction

    assign rd_word_c     = '{data: rd_data, upd: rd_updated};
    assign word_last_c   = (32'(word) == WORDS - 32'd1);
    assign prefetch_ok_c = ((32'(word) + 32'd2) < WORDS);

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cur       <= '0;
            nxt       <= '0;
            word      <= '0;
            slot      <= '0;
            rd_pend   <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            clr_en    <= 1'b0;
            clr_addr  <= '0;
            pix_valid <= 1'b0;
            pix_index <= '0;
            busy      <= 1'b0;
            line_done <= 1'b0;
        end else begin
            state     <= state_d;
            cur       <= cur_d;
            nxt       <= nxt_d;
            word      <= word_d;
            slot      <= slot_d;
            rd_pend   <= rd_pend_d;
            rd_en     <= rd_en_d;
            rd_addr   <= rd_addr_d;
            clr_en    <= clr_en_d;
            clr_addr  <= clr_addr_d;
            pix_valid <= pix_valid_d;
            pix_index <= pix_index_d;
            busy      <= busy_d;
            line_done <= line_done_d;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d     = state;
        cur_d       = cur;
        nxt_d       = nxt;
        word_d      = word;
        slot_d      = slot;
        rd_pend_d   = rd_en;
        rd_en_d     = 1'b0;
        rd_addr_d   = rd_addr;
        clr_en_d    = 1'b0;
        clr_addr_d  = clr_addr;
        pix_valid_d = 1'b0;
        pix_index_d = pix_index;
        line_done_d = 1'b0;

        case (state)
            IDLE: begin
                if (line_start) begin
                    state_d   = FETCH0;
                    word_d    = '0;
                    slot_d    = '0;
                    rd_en_d   = 1'b1;
                    rd_addr_d = '0;
                end
            end
            FETCH0: begin
                state_d   = FETCH1;
                rd_en_d   = 1'b1;
                rd_addr_d = ADDR_W'(1);
            end
            FETCH1: begin
                state_d = FETCH2;
                cur_d   = rd_word_c;
            end
            FETCH2: begin
                state_d = ACTIVE;
                nxt_d   = rd_word_c;
            end
            ACTIVE: begin
                // A prefetch issued after a word boundary lands here one cycle later.
                if (rd_pend) begin
                    nxt_d = rd_word_c;
                end
                if (pix_ce) begin
                    pix_valid_d = 1'b1;
                    pix_index_d = pick_pixel(cur, slot, bg_color);
                    slot_d      = slot + 2'd1;
                    if (slot == 2'd3) begin
                        cur_d = nxt;
`ifdef SCANOUT_CLEAR_EN
                        clr_en_d   = 1'b1;
                        clr_addr_d = word;
`endif
                        if (prefetch_ok_c) begin
                            rd_en_d   = 1'b1;
                            rd_addr_d = ADDR_W'(32'(word) + 32'd2);
                        end
                        if (word_last_c) begin
                            state_d     = IDLE;
                            line_done_d = 1'b1;
                        end else begin
                            word_d = word + ADDR_W'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

`ifndef SCANOUT_CLEAR_EN
        clr_en_d   = 1'b0;
        clr_addr_d = '0;
`endif
        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_line_scanout.sv
// Scoreboard bench for line_scanout: random lines checked against a slot/word arithmetic model.
module tb_line_scanout;
    localparam int unsigned WORDS  = 8;
    localparam int unsigned ADDR_W = 3;
    localparam int          NPIX   = 4 * WORDS;
`ifdef SCANOUT_CLEAR_EN
    localparam int          CLR_EXP = WORDS;
`else
    localparam int          CLR_EXP = 0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              line_start = 1'b0;
    logic              pix_ce = 1'b0;
    logic [8:0]        bg_color = 9'h000;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [35:0]       rd_data = '0;
    logic [3:0]        rd_updated = '0;
    logic              clr_en;
    logic [ADDR_W-1:0] clr_addr;
    logic              pix_valid;
    logic [8:0]        pix_index;
    logic              busy;
    logic              line_done;

    line_scanout #(.WORDS(WORDS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .line_start(line_start), .pix_ce(pix_ce),
        .bg_color(bg_color), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_updated(rd_updated), .clr_en(clr_en), .clr_addr(clr_addr),
        .pix_valid(pix_valid), .pix_index(pix_index), .busy(busy), .line_done(line_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [8:0] idx;
        logic       last;
    } exp_t;

    exp_t        q[$];
    logic [35:0] mem_d[WORDS];
    logic [3:0]  mem_f[WORDS];
    int          cyc = 0;
    int          k0 = -1000;
    int          rd_exp = 0;
    int          clr_cnt = 0;
    int          tests = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference pixel n of the line straight from the word/slot layout rules.
    function automatic logic [8:0] model_pix(input int n);
        int          w = n / 4;
        int          s = n % 4;
        logic [35:0] d = mem_d[w];
        logic [7:0]  b;
        logic        bank;
        logic        upd;
        bank = d[35 - s];
        b    = d[31 - 8*s -: 8];
        upd  = mem_f[w][3 - s];
        if (!upd || b[3:0] == 4'h0) return bg_color;
        return {bank, b};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Buffer read port: data and flags one cycle after rd_en.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data    <= mem_d[int'(rd_addr)];
            rd_updated <= mem_f[int'(rd_addr)];
        end
    end

    // Monitor: fetch/clear ordering, start-up timing and pixel scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cyc == k0 + 1) begin
                chk("start_busy", 64'(busy), 64'(1));
                chk("fetch0", 64'({rd_en, rd_addr}), 64'({1'b1, ADDR_W'(0)}));
            end
            if (cyc == k0 + 2) chk("fetch1", 64'({rd_en, rd_addr}), 64'({1'b1, ADDR_W'(1)}));
            if (rd_en) begin
                chk("rd_addr_order", 64'(rd_addr), 64'(rd_exp));
                rd_exp++;
            end
            if (clr_en) begin
                chk("clr_addr_order", 64'(clr_addr), 64'(clr_cnt));
                clr_cnt++;
            end
            if (pix_valid) begin
                if (q.size() == 0) begin
                    chk("pix_unexpected", 64'(pix_valid), 64'(0));
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("pix_cycle", 64'(cyc), 64'(e.cyc));
                    chk("pix_index", 64'(pix_index), 64'(e.idx));
                    chk("line_done", 64'(line_done), 64'(e.last));
                    if (e.last) chk("busy_fall", 64'(busy), 64'(0));
                end
            end else begin
                if (q.size() > 0 && q[0].cyc <= cyc) begin
                    chk("pix_missing", 64'(pix_valid), 64'(1));
                    void'(q.pop_front());
                end
                if (line_done) chk("line_done_alone", 64'(line_done), 64'(0));
            end
        end
    end

    task automatic fill_random();
        for (int w = 0; w < WORDS; w++) begin
            mem_d[w] = {4'($urandom), 32'($urandom)};
            mem_f[w] = 4'($urandom);
            if ($urandom_range(0, 2) == 0) mem_d[w][11:8] = 4'h0;
        end
        bg_color = 9'($urandom);
    endtask

    task automatic fill_directed();
        for (int w = 0; w < WORDS; w++) begin
            mem_d[w] = 36'h9_8182_8384;
            mem_f[w] = 4'hF;
        end
        mem_f[1] = 4'b1010;
        mem_d[2] = 36'hF_3091_A030;
        bg_color = 9'h05A;
    endtask

    task automatic check_reset_outs(input string name);
        chk(name, 64'({rd_en, rd_addr, clr_en, clr_addr, pix_valid, pix_index, busy, line_done}),
            64'(0));
    endtask

    // mode 0: pix_ce every cycle, 1: every 3rd cycle, 2: random with a stray line_start.
    task automatic run_line(input int mode, input int abort_at);
        int   consumed;
        int   rel;
        logic ce;
        exp_t e;
        consumed = 0;
        line_start = 1'b1;
        k0 = cyc;
        rd_exp = 0;
        clr_cnt = 0;
        @(posedge clk); #1;
        line_start = 1'b0;
        while (consumed < NPIX && (cyc - k0) < 40 * WORDS) begin
            rel = cyc - k0;
            if (abort_at >= 0 && consumed == abort_at) begin
                rst_n = 1'b0;
                pix_ce = 1'b0;
                q.delete();
                k0 = -1000;
                @(negedge clk);
                check_reset_outs("abort_reset_outs");
                @(posedge clk); #1;
                rst_n = 1'b1;
                return;
            end
            case (mode)
                0:       ce = 1'b1;
                1:       ce = (rel % 3 == 0);
                default: ce = 1'($urandom_range(0, 1));
            endcase
            line_start = (mode == 2 && rel == 20);
            pix_ce = ce;
            if (ce && rel >= 4) begin
                e.cyc  = cyc + 1;
                e.idx  = model_pix(consumed);
                e.last = (consumed == NPIX - 1);
                q.push_back(e);
                consumed++;
            end
            @(posedge clk); #1;
        end
        pix_ce = 1'b0;
        line_start = 1'b0;
        chk("line_budget", 64'(consumed), 64'(NPIX));
        repeat (3) @(posedge clk);
        #1;
        chk("q_drained", 64'(q.size()), 64'(0));
        chk("idle_busy", 64'(busy), 64'(0));
        chk("rd_count", 64'(rd_exp), 64'(WORDS));
        chk("clr_count", 64'(clr_cnt), 64'(CLR_EXP));
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int w = 0; w < WORDS; w++) begin
            mem_d[w] = '0;
            mem_f[w] = '0;
        end
        @(negedge clk);
        check_reset_outs("reset_outs");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        fill_directed();
        run_line(0, -1);
        fill_random();
        run_line(0, -1);
        fill_random();
        run_line(1, -1);
        fill_random();
        run_line(2, -1);
        fill_random();
        run_line(0, 13);
        fill_random();
        run_line(0, -1);
        fill_random();
        run_line(2, -1);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d tests run", tests);
        $fatal(1, "timeout");
    end
endmodule
